iccm_arbiter: RTL and testbench

- Sequences and shares the single-port instruction memory (ICCM, 4 KiB words at 12-bit word address) between two requesters:
  - the UART boot programmer write stream;
  - the instruction-fetch read path coming from the TL-UL SRAM adapter.
- Buffers programmer writes, arbitrates with starvation protection, and blocks read-after-write hazards.
- Drains pending writes before signalling that programming is complete, so the system reset can be released safely.

---
 rtl/iccm_arb_pkg.sv | 17 +
 rtl/iccm_wbuf.sv | 67 ++++++
 rtl/iccm_arbiter.sv | 109 ++++++++++
 tb/tb_iccm_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/iccm_arb_pkg.sv
// Shared types and default sizing for the ICCM arbiter and its write buffer.
package iccm_arb_pkg;
    localparam int ICCM_AW         = 12;
    localparam int ICCM_DW         = 32;
    localparam int ICCM_WBUF_DEPTH = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PROG  = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [ICCM_AW-1:0] addr;
        logic [ICCM_DW-1:0] data;
    } wbuf_entry_t;
endpackage

// File: rtl/iccm_wbuf.sv
// Programmer write FIFO; exposes which valid entries match a probe address.
module iccm_wbuf
    import iccm_arb_pkg::*;
#(
    parameter int AW    = ICCM_AW,
    parameter int DW    = ICCM_DW,
    parameter int DEPTH = ICCM_WBUF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [AW-1:0]    push_addr,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    input  logic [AW-1:0]    match_addr,
    output logic [AW-1:0]    head_addr,
    output logic [DW-1:0]    head_data,
    output logic             full,
    output logic             empty,
    output logic [DEPTH-1:0] match_vec
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: every consumer is qualified by count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_q[wptr] <= push_addr;
            data_q[wptr] <= push_data;
        end
    end

    assign head_addr = addr_q[rptr];
    assign head_data = data_q[rptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [PW-1:0] off;
        assign off          = PW'(i) - rptr;
        assign match_vec[i] = ({1'b0, off} < count) && (addr_q[i] == match_addr);
    end
endmodule

// File: rtl/iccm_arbiter.sv
// Shares the single-port ICCM between the boot-programmer write stream and
// instruction fetch reads, with starvation protection and RAW hazard stalls.
module iccm_arbiter
    import iccm_arb_pkg::*;
#(
    parameter int AW          = ICCM_AW,
    parameter int DW          = ICCM_DW,
    parameter int WBUF_DEPTH  = ICCM_WBUF_DEPTH,
    parameter int MAX_RD_WINS = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          prog_mode_i,
    input  logic          wr_req_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    output logic          wr_gnt_o,
    input  logic          rd_req_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic          rd_gnt_o,
    output logic          rd_rvalid_o,
    output logic [DW-1:0] rd_rdata_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [3:0]    mem_wmask_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_rvalid_i,
    output logic          wbuf_empty_o,
    output logic          prog_done_o
);
    localparam int CW = $clog2(MAX_RD_WINS + 1);

    arb_state_e          state, state_nxt;
    logic [CW-1:0]       starve;
    logic                wb_full, wb_empty;
    logic [AW-1:0]       head_addr;
    logic [DW-1:0]       head_data;
    logic [WBUF_DEPTH-1:0] hit_vec;
    logic                rd_elig, wr_pend, wr_prio, rd_issue, wr_issue;

    iccm_wbuf #(.AW(AW), .DW(DW), .DEPTH(WBUF_DEPTH)) u_wbuf (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .push       (wr_gnt_o),
        .push_addr  (wr_addr_i),
        .push_data  (wr_data_i),
        .pop        (wr_issue),
        .match_addr (rd_addr_i),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (wb_full),
        .empty      (wb_empty),
        .match_vec  (hit_vec)
    );

    assign wr_gnt_o = wr_req_i & ~wb_full;

    // A read to an address still sitting in the buffer waits for it to drain.
    assign rd_elig  = rd_req_i & (state == RUN) & ~|hit_vec;
    assign wr_pend  = ~wb_empty;
    assign wr_prio  = wb_full | (starve >= CW'(MAX_RD_WINS));
    assign rd_issue = rd_elig & ~(wr_pend & wr_prio);
    assign wr_issue = wr_pend & ~rd_issue;

    assign rd_gnt_o    = rd_issue;
    assign mem_req_o   = rd_issue | wr_issue;
    assign mem_we_o    = wr_issue;
    assign mem_addr_o  = wr_issue ? head_addr : (rd_issue ? rd_addr_i : '0);
    assign mem_wdata_o = wr_issue ? head_data : '0;
    assign mem_wmask_o = {4{wr_issue}};

    assign rd_rvalid_o  = mem_rvalid_i;
    assign rd_rdata_o   = mem_rdata_i;
    assign wbuf_empty_o = wb_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            starve <= '0;
        else if (wr_issue)
            starve <= '0;
        else if (rd_issue && wr_pend && starve != CW'(MAX_RD_WINS))
            starve <= starve + 1'b1;
    end

    always_comb begin
        state_nxt   = state;
        prog_done_o = 1'b0;
        case (state)
            RUN:   if (prog_mode_i) state_nxt = PROG;
            PROG:  if (!prog_mode_i) state_nxt = FLUSH;
            FLUSH: begin
                if (prog_mode_i) begin
                    state_nxt = PROG;
                end else if (wb_empty && !wr_issue) begin
                    state_nxt   = RUN;
                    prog_done_o = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= RUN;
        else         state <= state_nxt;
    end
endmodule

// File: tb/tb_iccm_arbiter.sv
// Random and directed checks of iccm_arbiter against a queue-based reference model.
module tb_iccm_arbiter;
    import iccm_arb_pkg::*;

    localparam int AW = 12, DW = 32, DEPTH = 4, MAXW = 8;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          prog_mode_i = 1'b0, wr_req_i = 1'b0, rd_req_i = 1'b0;
    logic [AW-1:0] wr_addr_i = '0, rd_addr_i = '0;
    logic [DW-1:0] wr_data_i = '0;
    logic          wr_gnt_o, rd_gnt_o, rd_rvalid_o, mem_req_o, mem_we_o;
    logic [DW-1:0] rd_rdata_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [3:0]    mem_wmask_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_rvalid_i = 1'b0;
    logic          wbuf_empty_o, prog_done_o;

    always #5 clk = ~clk;

    iccm_arbiter dut (
        .clk_i(clk), .rst_ni(rst_ni), .prog_mode_i(prog_mode_i),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_gnt_o(wr_gnt_o),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
        .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
        .wbuf_empty_o(wbuf_empty_o), .prog_done_o(prog_done_o)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {20'hC0DE0, a};
    endfunction

    // Memory: one-cycle read latency, returns 0 on idle cycles.
    logic [DW-1:0] mem [4096];
    logic          mem_wr [4096];
    always @(posedge clk) begin
        mem_rvalid_i <= mem_req_o & ~mem_we_o;
        mem_rdata_i  <= (mem_req_o & ~mem_we_o) ?
                        ((mem_wr[mem_addr_o] === 1'b1) ? mem[mem_addr_o] : init_val(mem_addr_o)) : '0;
        if (mem_req_o & mem_we_o) begin
            mem[mem_addr_o]    <= mem_wdata_o;
            mem_wr[mem_addr_o] <= 1'b1;
        end
    end

    // Reference model state
    wbuf_entry_t   q[$];
    arb_state_e    st = RUN;
    int            starve = 0;
    logic          pend_rd = 1'b0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] shadow [4096];
    logic          sh_wr [4096];
    int            total = 0, bad = 0;
    int            wait_run = 0, max_wait = 0;
    logic          obs_rvalid, obs_wgnt, obs_we;
    logic [DW-1:0] obs_rdata;

    function automatic logic [DW-1:0] sh_rd(input logic [AW-1:0] a);
        return (sh_wr[a] === 1'b1) ? shadow[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic p, input logic wq, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic rq, input logic [AW-1:0] ra);
        logic e_wgnt, hit, rd_ok, rd_win, wr_win, was_empty, e_done;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        @(negedge clk);
        prog_mode_i = p; wr_req_i = wq; wr_addr_i = wa; wr_data_i = wd;
        rd_req_i = rq; rd_addr_i = ra;
        #1;
        was_empty = (q.size() == 0);
        e_wgnt = wq && (q.size() < DEPTH);
        hit = 1'b0;
        foreach (q[i]) if (q[i].addr == ra) hit = 1'b1;
        rd_ok  = rq && (st == RUN) && !hit;
        if (!was_empty && rd_ok) rd_win = !(q.size() == DEPTH || starve >= MAXW);
        else                     rd_win = rd_ok;
        wr_win  = !was_empty && !rd_win;
        e_addr  = wr_win ? q[0].addr : (rd_win ? ra : '0);
        e_wdata = wr_win ? q[0].data : '0;
        e_done  = (st == FLUSH) && !p && was_empty;

        chk("wr_gnt", wr_gnt_o, e_wgnt);
        chk("rd_gnt", rd_gnt_o, rd_win);
        chk("mem_ctl", {mem_req_o, mem_we_o, mem_wmask_o}, {rd_win | wr_win, wr_win, {4{wr_win}}});
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wdata", mem_wdata_o, e_wdata);
        chk("flags", {wbuf_empty_o, prog_done_o}, {was_empty, e_done});
        chk("rvalid", rd_rvalid_o, pend_rd);
        chk("rdata", rd_rdata_o, pend_rd ? pend_data : '0);
        obs_rvalid = rd_rvalid_o; obs_rdata = rd_rdata_o;
        obs_wgnt = wr_gnt_o; obs_we = mem_req_o & mem_we_o;

        if (!wbuf_empty_o && !(mem_req_o && mem_we_o)) wait_run++;
        else wait_run = 0;
        if (wait_run > max_wait) max_wait = wait_run;

        @(posedge clk);
        pend_rd   = rd_win;
        pend_data = rd_win ? sh_rd(ra) : '0;
        if (wr_win) begin
            shadow[q[0].addr] = q[0].data;
            sh_wr[q[0].addr]  = 1'b1;
            void'(q.pop_front());
            starve = 0;
        end else if (rd_win && !was_empty) begin
            starve = (starve < MAXW) ? starve + 1 : MAXW;
        end
        if (e_wgnt) q.push_back('{addr: wa, data: wd});
        case (st)
            RUN:   if (p) st = PROG;
            PROG:  if (!p) st = FLUSH;
            FLUSH: if (p) st = PROG; else if (was_empty) st = RUN;
            default: st = RUN;
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        prog_mode_i = 1'b0; wr_req_i = 1'b0; rd_req_i = 1'b0;
        #1;
        chk("rst_state", {wbuf_empty_o, prog_done_o, mem_req_o, rd_gnt_o}, 4'b1000);
        q.delete(); st = RUN; starve = 0; wait_run = 0;
        repeat (2) @(posedge clk);
        pend_rd = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        int n;
        logic saw_full;
        logic p;
        #1;
        chk("rst_ctl", {wr_gnt_o, rd_gnt_o, mem_req_o, mem_we_o, mem_wmask_o, prog_done_o, rd_rvalid_o}, '0);
        chk("rst_addr", mem_addr_o, '0);
        chk("rst_wdata", mem_wdata_o, '0);
        chk("rst_empty", wbuf_empty_o, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;

        // First read: same-cycle grant, data one cycle later.
        step(0, 0, '0, '0, 1, 12'h010);
        step(0, 0, '0, '0, 0, '0);
        chk("first_rd", {obs_rvalid, obs_rdata}, {1'b1, init_val(12'h010)});

        // Programming burst, then release and flush.
        step(1, 0, '0, '0, 1, 12'h100);
        for (int i = 0; i < 4; i++) begin
            step(1, 1, AW'(i), DW'(32'hA0 + i), 1, 12'h100);
            chk("prog_wgnt", obs_wgnt, 1'b1);
        end
        for (int i = 0; i < 6; i++) step(0, 0, '0, '0, 1, 12'h100);

        // RAW hazard: read stalls behind the buffered write, then sees new data.
        step(0, 1, 12'h020, 32'hDEAD, 0, '0);
        step(0, 0, '0, '0, 1, 12'h020);
        step(0, 0, '0, '0, 1, 12'h020);
        step(0, 0, '0, '0, 0, '0);
        chk("haz_data", {obs_rvalid, obs_rdata}, {1'b1, 32'h0000DEAD});

        // Starvation bound: one write against continuous reads.
        step(0, 1, 12'h300, 32'h1234, 1, 12'h001);
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step(0, 0, '0, '0, 1, AW'(i));
            if (obs_we) n = i;
        end
        chk("starve_wait", n, 9);

        // Fill the buffer against reads, then reset mid-stream in PROG.
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, AW'(12'h400 + i), DW'(i), 1, AW'(12'h040 + i));
            if (!obs_wgnt) saw_full = 1'b1;
        end
        chk("full_block", saw_full, 1'b1);
        step(1, 1, 12'h500, 32'h5, 0, '0);
        step(1, 1, 12'h501, 32'h6, 0, '0);
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, '0, '0, 0, '0);

        // Random traffic with small address range to provoke hazards.
        p = 1'b0;
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 400; c++) begin
                if ($urandom_range(0, 40) == 0) p = ~p;
                if ($urandom_range(0, 600) == 0) do_reset();
                step(p,
                     ($urandom_range(0, 9) < 2 + 2*ph),
                     AW'($urandom_range(0, 7)), DW'($urandom),
                     ($urandom_range(0, 9) < 9 - ph),
                     AW'($urandom_range(0, 7)));
            end
        end
        for (int i = 0; i < 12; i++) step(0, 0, '0, '0, 0, '0);
        chk("starve_max", (max_wait <= MAXW), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
